// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem_responder memory model.
package pmem_pkg;

    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_W         = 64;
    localparam int LINE_BYTES     = 32;
    localparam int ADDR_W         = 32;

    localparam int BEAT_IDX_W = $clog2(BEATS_PER_LINE);
    localparam int OFFSET_W   = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } pmem_state_e;

    // Byte address to full line number; the caller truncates to its depth.
    function automatic logic [ADDR_W-1:0] line_number(
        input logic [ADDR_W-1:0] addr
    );
        return addr >> OFFSET_W;
    endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Requester <-> responder burst bus: request held, four strobed beats.
interface pmem_responder_if;
    import pmem_pkg::*;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp
    );

endinterface

// File: rtl/pmem_line_array.sv
// Single-port word store: synchronous write, registered read.
module pmem_line_array
    import pmem_pkg::*;
#(
    parameter int WORD_W = 10,
    parameter int DATA_W = BEAT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**WORD_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pmem_responder.sv
// Burst memory responder with fixed latency and four-beat lines.
// Optional sticky protocol error output: define PMEM_RESPONDER_ERR_EN.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic             clk,
    input  logic             rst,
    pmem_responder_if.slave  bus
`ifdef PMEM_RESPONDER_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int LINE_W = $clog2(DEPTH_LINES);
    localparam int WORD_W = LINE_W + BEAT_IDX_W;
    localparam int LAT_W  = 4;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] BURST = ST_BURST;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT =
        BEAT_IDX_W'(BEATS_PER_LINE - 1);

    logic [1:0]            state;
    logic [LAT_W-1:0]      lat_cnt;
    logic [BEAT_IDX_W-1:0] beat;
    logic [LINE_W-1:0]     line;
    logic                  is_wr;

    logic                  req_any;
    logic                  req_act;
    logic                  accept;
    logic                  drop;
    logic                  burst_on;
    logic [BEAT_IDX_W-1:0] sel_beat;
    logic [WORD_W-1:0]     word_addr;
    logic                  arr_we;
    logic [BEAT_W-1:0]     arr_rdata;

    assign req_any  = bus.pmem_read | bus.pmem_write;
    assign req_act  = is_wr ? bus.pmem_write : bus.pmem_read;
    assign accept   = (state == IDLE) && req_any;
    assign drop     = ((state == WAIT) || (state == BURST)) && !req_act;
    assign burst_on = (state == BURST) && req_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
            line    <= '0;
            is_wr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= WAIT;
                        line    <= LINE_W'(line_number(bus.pmem_address));
                        is_wr   <= bus.pmem_write;
                        lat_cnt <= LAT_LOAD;
                        beat    <= '0;
                    end
                end
                WAIT: begin
                    if (drop) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                    end else if (lat_cnt == '0) begin
                        state <= BURST;
                        beat  <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                BURST: begin
                    if (drop) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reads look one beat ahead so the registered word lands with its strobe.
    always_comb begin
        sel_beat = beat;
        if ((state == BURST) && !is_wr) begin
            sel_beat = beat + 1'b1;
        end
    end

    assign word_addr = {line, sel_beat};
    assign arr_we    = burst_on && is_wr;

    pmem_line_array #(
        .WORD_W (WORD_W),
        .DATA_W (BEAT_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (word_addr),
        .wdata (bus.pmem_wdata),
        .rdata (arr_rdata)
    );

    assign bus.pmem_resp  = burst_on;
    assign bus.pmem_rdata = (burst_on && !is_wr) ? arr_rdata : '0;

`ifdef PMEM_RESPONDER_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((accept && bus.pmem_read && bus.pmem_write) || drop) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: cycle-indexed expectation model plus literals.
module tb_pmem_responder;
    import pmem_pkg::*;

    localparam int NCYC = 2048;
    localparam int DL   = 256;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    pmem_responder_if b4();
    pmem_responder_if b1();

`ifdef PMEM_RESPONDER_ERR_EN
    logic err4;
    logic err1;
`endif

    pmem_responder #(.LATENCY(4), .DEPTH_LINES(DL)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
`ifdef PMEM_RESPONDER_ERR_EN
        ,
        .err (err4)
`endif
    );

    pmem_responder #(.LATENCY(1), .DEPTH_LINES(DL)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
`ifdef PMEM_RESPONDER_ERR_EN
        ,
        .err (err1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: word store per DUT and expected strobe/data per cycle.
    logic [63:0] mdl [2][DL*4];
    bit          er  [2][NCYC];
    bit          edc [2][NCYC];
    logic [63:0] ed  [2][NCYC];

    logic [63:0] cq0 [$];
    logic [63:0] cq1 [$];
    int          cc0 [$];
    int          cc1 [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_out(input int w, input logic r,
                             input logic [63:0] d);
        logic [63:0] xd;
        xd = er[w][cyc] ? ed[w][cyc] : 64'd0;
        chk($sformatf("resp%0d@%0d", w, cyc), {63'd0, r},
            {63'd0, er[w][cyc]});
        if (!er[w][cyc] || edc[w][cyc])
            chk($sformatf("rdata%0d@%0d", w, cyc), d, xd);
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            check_out(0, b4.pmem_resp, b4.pmem_rdata);
            check_out(1, b1.pmem_resp, b1.pmem_rdata);
            if (b4.pmem_resp) begin
                cq0.push_back(b4.pmem_rdata);
                cc0.push_back(cyc);
            end
            if (b1.pmem_resp) begin
                cq1.push_back(b1.pmem_rdata);
                cc1.push_back(cyc);
            end
        end
    end

    task automatic drive(input int w, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [63:0] d);
        if (w == 0) begin
            b4.pmem_read = rd;
            b4.pmem_write = wr;
            b4.pmem_address = a;
            b4.pmem_wdata = d;
        end else begin
            b1.pmem_read = rd;
            b1.pmem_write = wr;
            b1.pmem_address = a;
            b1.pmem_wdata = d;
        end
    endtask

    // One request held for nb beats (nb < 4 drops it early).
    task automatic xact(input int w, input bit rd, input bit wr,
                        input logic [31:0] addr,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [63:0] d3,
                        input int nb, output int acc);
        logic [63:0] d [4];
        int lat, first, ln;
        d = '{d0, d1, d2, d3};
        lat = (w == 0) ? 4 : 1;
        ln = int'((addr >> 5) % DL);
        acc = cyc + 1;
        first = acc + lat;
        for (int k = 0; k < nb; k++) begin
            er[w][first+k] = 1'b1;
            if (!wr) begin
                ed[w][first+k] = mdl[w][ln*4+k];
                edc[w][first+k] = 1'b1;
            end
        end
        if (wr) for (int k = 0; k < nb; k++) mdl[w][ln*4+k] = d[k];
        while (cyc < first + nb) begin
            drive(w, rd, wr, addr, d[(cyc >= first) ? cyc - first : 0]);
            @(posedge clk); #1;
        end
        drive(w, 1'b0, 1'b0, 32'd0, 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic read4(input logic [31:0] addr, output int acc);
        cq0.delete();
        cc0.delete();
        xact(0, 1'b1, 1'b0, addr, 0, 0, 0, 0, 4, acc);
    endtask

    task automatic lit4(input string nm, input logic [63:0] x0,
                        input logic [63:0] x1, input logic [63:0] x2,
                        input logic [63:0] x3);
        logic [63:0] x [4];
        x = '{x0, x1, x2, x3};
        chk({nm, "_nbeats"}, 64'(cq0.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_beat%0d", nm, k),
                (k < cq0.size()) ? cq0[k] : 64'hDEAD, x[k]);
    endtask

    initial begin
        int acc;
        int first;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DL*4; i++) mdl[w][i] = 64'd0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 64'd0);
        #1;
        chk("reset_resp", {63'd0, b4.pmem_resp}, 64'd0);
        chk("reset_rdata", b4.pmem_rdata, 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;

        xact(1, 1'b1, 1'b0, 32'h40, 0, 0, 0, 0, 4, acc);
        chk("lat1_nbeats", 64'(cq1.size()), 64'd4);
        chk("lat1_first", 64'(cc1[0] - acc), 64'd1);
        chk("lat1_data0", cq1[0], 64'd0);

        xact(0, 1'b0, 1'b1, 32'h100, 64'hA0A0_0000_0000_0000,
             64'hA1A1_1111_1111_1111, 64'hA2A2_2222_2222_2222,
             64'hA3A3_3333_3333_3333, 4, acc);
        read4(32'h100, acc);
        lit4("rd100", 64'hA0A0_0000_0000_0000, 64'hA1A1_1111_1111_1111,
             64'hA2A2_2222_2222_2222, 64'hA3A3_3333_3333_3333);
        chk("lat4_first", 64'(cc0[0] - acc), 64'd4);
        chk("lat4_span", 64'(cc0[3] - cc0[0]), 64'd3);

        xact(0, 1'b1, 1'b1, 32'h20, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 4, acc);
        read4(32'h20, acc);
        lit4("rdwr20", 64'hB0, 64'hB1, 64'hB2, 64'hB3);
`ifdef PMEM_RESPONDER_ERR_EN
        chk("err_rdwr", {63'd0, err4}, 64'd1);
        chk("err_other", {63'd0, err1}, 64'd0);
`endif

        xact(0, 1'b0, 1'b1, 32'h80, 64'hC0, 64'hC1, 64'hC2, 64'hC3, 4, acc);
        xact(0, 1'b0, 1'b1, 32'h80, 64'hD0, 64'hD1, 64'hD2, 64'hD3, 2, acc);
        read4(32'h80, acc);
        lit4("drop80", 64'hD0, 64'hD1, 64'hC2, 64'hC3);

        xact(0, 1'b0, 1'b1, 32'h2000, 64'hE0, 64'hE1, 64'hE2, 64'hE3, 4, acc);
        read4(32'h0000, acc);
        lit4("alias0", 64'hE0, 64'hE1, 64'hE2, 64'hE3);

        // Read 0x100 and hit reset during beat 2.
        acc = cyc + 1;
        first = acc + 4;
        for (int k = 0; k < 2; k++) begin
            er[0][first+k] = 1'b1;
            edc[0][first+k] = 1'b1;
            ed[0][first+k] = mdl[0][8*4+k];
        end
        while (cyc < first + 2) begin
            drive(0, 1'b1, 1'b0, 32'h100, 64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 64'd0);
        #1;
        chk("rst_mid_resp", {63'd0, b4.pmem_resp}, 64'd0);
        chk("rst_mid_rdata", b4.pmem_rdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
`ifdef PMEM_RESPONDER_ERR_EN
        chk("err_cleared", {63'd0, err4}, 64'd0);
`endif
        read4(32'h100, acc);
        lit4("after_rst", 64'hA0A0_0000_0000_0000, 64'hA1A1_1111_1111_1111,
             64'hA2A2_2222_2222_2222, 64'hA3A3_3333_3333_3333);

        repeat (3) begin @(posedge clk); #1; end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request acceptance to first response beat (legal 1..15).
REQ-002 SHALL have parameter DEPTH_LINES, default 256, number of 32-byte lines in backing store (power of two).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pmem_read  input  1  requester read request, held until the last beat completes.
REQ-006 pmem_write  input  1  requester write request, held until the last beat completes.
REQ-007 pmem_address  input  32  line address; bits [4:0] ignored.
REQ-008 pmem_wdata  input  64  write beat; requester advances it after each pmem_resp cycle.
REQ-009 pmem_rdata  output  64  read beat, valid only while pmem_resp is high.
REQ-010 pmem_resp  output  1  beat strobe, high for exactly 4 consecutive cycles per completed burst.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, BURST, DONE.
REQ-012 IDLE: when pmem_read or pmem_write is sampled high, SHALL latch address and direction, load latency counter, and go to WAIT.
REQ-013 WAIT: SHALL assert pmem_resp first in the cycle LATENCY cycles after the accepting edge, then enter BURST with beat counter 0.
REQ-014 BURST: SHALL hold pmem_resp high for beats 0..3, beat k addressing word (line, k), counter wrapping 3->0 on exit to DONE.
REQ-015 Read beat k SHALL drive pmem_rdata = store[line][k] registered, aligned with its pmem_resp cycle.
REQ-016 Write beat k SHALL commit pmem_wdata to store[line][k] on the edge ending that pmem_resp cycle.
REQ-017 DONE: SHALL hold pmem_resp low one cycle and return to IDLE; a request still high in DONE SHALL NOT be accepted until IDLE.
REQ-018 Line index SHALL be pmem_address[4+log2(DEPTH_LINES):5]; upper address bits SHALL be ignored (wrap-around aliasing).
REQ-019 If pmem_read and pmem_write are both high at acceptance, write SHALL take priority.
REQ-020 If the active request drops in WAIT or BURST, SHALL abort to IDLE next edge; beats already written remain, no further pmem_resp.
REQ-021 pmem_rdata SHALL be 0 whenever pmem_resp is low.

Reset
REQ-022 On rst: state IDLE, pmem_resp 0, pmem_rdata 0, counters 0, immediately and independent of clk.
REQ-023 Reset mid-burst SHALL abort the burst; backing store contents SHALL NOT be cleared.

Configuration
REQ-024 With PMEM_RESPONDER_ERR_EN defined, SHALL add output err (1 bit, reset 0), sticky-set on simultaneous read+write at acceptance or on a request drop per REQ-020, cleared only by rst.
REQ-025 Without PMEM_RESPONDER_ERR_EN, err port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Shared package pmem_pkg SHALL hold state enum, BEATS_PER_LINE=4, BEAT_W=64, LINE_BYTES=32, ADDR_W=32.
REQ-027 Backing store SHALL be sub-module pmem_line_array (1 port, word-addressed by {line, beat}, sync write, registered read).

Verification
REQ-028 Write 0x100 beats {A0,A1,A2,A3}, then read 0x100 -> pmem_resp 4 cycles each; read returns A0..A3 in order, first beat 4 cycles after acceptance.
REQ-029 LATENCY=1, read 0x40 immediately after reset -> pmem_resp at accept+1, data 0 for uninitialised store by bench preload 0.
REQ-030 Read+write both high at 0x20 -> write performed; with PMEM_RESPONDER_ERR_EN, err=1 next cycle and stays 1.
REQ-031 Drop pmem_write after beat 1 at 0x80 -> only words 0,1 updated, pmem_resp low next cycle, FSM IDLE.
REQ-032 DEPTH_LINES=256, write 0x2000, read 0x0000 -> same data (aliasing).
REQ-033 Assert rst during BURST beat 2 -> pmem_resp and pmem_rdata 0 same cycle; subsequent read returns prior data.
